// File: rtl/mul_vector_seq.sv
// Sequential unsigned multi-limb multiplier.
// Schoolbook multiply-accumulate with one limb partial product per clock and a
// start/done handshake. Result latency is N_LIMBS^2+1 clocks from the accept edge.
module mul_vector_seq #(
  parameter int LIMB_W  = 16,
  parameter int N_LIMBS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [N_LIMBS*LIMB_W-1:0]     a,
  input  logic [N_LIMBS*LIMB_W-1:0]     b,
  output logic                          busy,
  output logic                          done,
  output logic [2*N_LIMBS*LIMB_W-1:0]   y
);

  localparam int OW = N_LIMBS * LIMB_W;
  localparam int YW = 2 * OW;
  localparam int PW = 2 * LIMB_W;
  localparam int IW = (N_LIMBS > 1) ? $clog2(N_LIMBS) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_LIMBS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t                          state;
  logic [N_LIMBS-1:0][LIMB_W-1:0]  ra, rb;
  logic [YW-1:0]                   acc;
  logic [IW-1:0]                   i, j;
  logic [PW-1:0]                   prod;
  logic [YW-1:0]                   sum;

  // Current limb product, placed at limb position i+j and added to the accumulator.
  always_comb begin
    prod = PW'(ra[i]) * PW'(rb[j]);
    sum  = acc + (YW'(prod) << (LIMB_W * (int'(i) + int'(j))));
  end

  // Control FSM; busy/done/y are registered so they change only on clock edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      y     <= '0;
      acc   <= '0;
      ra    <= '0;
      rb    <= '0;
      i     <= '0;
      j     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= b;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
            busy  <= 1'b1;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          acc <= sum;
          if (i == LAST && j == LAST) begin
            // Final product goes straight to y so the result is visible with done.
            y     <= sum;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (j == LAST) begin
            j <= '0;
            i <= i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_vector_seq.sv
// Bench for mul_vector_seq: a 2x16 instance and a 4x8 instance share a clock.
// A cycle-count model predicts busy/done/y for both on every cycle.
module tb_mul_vector_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s0, s1, busy0, busy1, done0, done1;
  logic [31:0] a0, b0, a1, b1;
  logic [63:0] y0, y1;

  mul_vector_seq #(.LIMB_W(16), .N_LIMBS(2)) dut0 (
    .clk(clk), .rst(rst), .start(s0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .y(y0));

  mul_vector_seq #(.LIMB_W(8), .N_LIMBS(4)) dut1 (
    .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .y(y1));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: remaining busy cycles after each edge; done in the last one.
  int          m_cnt [2];
  logic [63:0] m_pend[2];
  logic [63:0] m_y   [2];
  bit          armed = 0;

  task automatic mstep(input int d, input logic st, input logic [31:0] a, input logic [31:0] b,
                       input int lat);
    if (rst) begin
      m_cnt[d] = 0;
      m_y[d]   = '0;
    end else if (m_cnt[d] == 0) begin
      if (st) begin
        m_cnt[d]  = lat;
        m_pend[d] = 64'(a) * 64'(b);
      end
    end else begin
      m_cnt[d]--;
    end
    if (m_cnt[d] == 1) m_y[d] = m_pend[d];
  endtask

  always @(posedge clk) begin
    if (rst) armed = 1;
    mstep(0, s0, a0, b0, 5);
    mstep(1, s1, a1, b1, 17);
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("busy0", 64'(busy0), 64'(m_cnt[0] != 0));
      chk("done0", 64'(done0), 64'(m_cnt[0] == 1));
      chk("y0",    y0,         m_y[0]);
      chk("busy1", 64'(busy1), 64'(m_cnt[1] != 0));
      chk("done1", 64'(done1), 64'(m_cnt[1] == 1));
      chk("y1",    y1,         m_y[1]);
    end
  end

  // One operation: request on a negedge, count cycles after the accept edge until done.
  task automatic op(input int d, input logic [31:0] aa, input logic [31:0] bb,
                    output int lat, output logic first_busy);
    @(negedge clk);
    if (d == 0) begin a0 = aa; b0 = bb; s0 = 1'b1; end
    else        begin a1 = aa; b1 = bb; s1 = 1'b1; end
    lat = 0;
    first_busy = 1'b0;
    do begin
      @(negedge clk);
      s0 = 1'b0; s1 = 1'b0;
      // Operands must not matter after the accept edge.
      if (d == 0) begin a0 = $urandom; b0 = $urandom; end
      else        begin a1 = $urandom; b1 = $urandom; end
      lat++;
      if (lat == 1) first_busy = (d == 0) ? busy0 : busy1;
    end while (!((d == 0) ? done0 : done1) && lat < 40);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat, nd, dc;
    logic        fb;
    logic [31:0] ra, rb;
    logic [63:0] yfirst;

    rst = 1'b1; s0 = 1'b0; s1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state, then idle with start low.
    chk("rst_y0", y0, 64'h0);
    chk("rst_busy0", 64'(busy0), 64'h0);
    chk("rst_done0", 64'(done0), 64'h0);
    repeat (3) @(negedge clk);
    chk("idle_y0", y0, 64'h0);
    chk("idle_busy0", 64'(busy0), 64'h0);

    // Basic product.
    op(0, 32'h0003_0002, 32'h0005_0004, lat, fb);
    chk("t2_first_busy", 64'(fb), 64'h1);
    chk("t2_lat", 64'(lat), 64'd5);
    chk("t2_y", y0, 64'h0000_000F_0016_0008);

    // Full carry propagation.
    op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, fb);
    chk("t3_lat", 64'(lat), 64'd5);
    chk("t3_y", y0, 64'hFFFF_FFFE_0000_0001);

    // Start held high through MUL and DONE with new operands.
    @(negedge clk);
    a0 = 32'h0003_0002; b0 = 32'h0005_0004; s0 = 1'b1;
    nd = 0; dc = 0; yfirst = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      a0 = 32'h1; b0 = 32'h1;
      if (done0) begin nd++; dc = c; yfirst = y0; end
      if (c == 6) chk("t4_idle_busy", 64'(busy0), 64'h0);
    end
    chk("t4_done_count", 64'(nd), 64'd1);
    chk("t4_done_cycle", 64'(dc), 64'd5);
    chk("t4_y_first", yfirst, 64'h0000_000F_0016_0008);
    @(negedge clk);
    s0 = 1'b0;
    chk("t4_reaccept_busy", 64'(busy0), 64'h1);
    lat = 1;
    while (!done0 && lat < 40) begin @(negedge clk); lat++; end
    chk("t4_lat2", 64'(lat), 64'd5);
    chk("t4_y_second", y0, 64'h1);

    // Reset during the second MUL cycle.
    @(negedge clk);
    a0 = 32'h0003_0002; b0 = 32'h0005_0004; s0 = 1'b1;
    @(negedge clk);
    s0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", 64'(busy0), 64'h0);
    chk("t5_done", 64'(done0), 64'h0);
    chk("t5_y", y0, 64'h0);
    op(0, 32'h0003_0002, 32'h0005_0004, lat, fb);
    chk("t5_lat", 64'(lat), 64'd5);
    chk("t5_y_after", y0, 64'h0000_000F_0016_0008);

    // Random operations on the 2x16 instance with random idle gaps.
    for (int k = 0; k < 200; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ra = pick(); rb = pick();
      op(0, ra, rb, lat, fb);
      chk("r0_lat", 64'(lat), 64'd5);
      chk("r0_y", y0, 64'(ra) * 64'(rb));
    end

    // 4x8 instance: literal anchors, then random operands.
    op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, fb);
    chk("t6_lat_ff", 64'(lat), 64'd17);
    chk("t6_y_ff", y1, 64'hFFFF_FFFE_0000_0001);
    op(1, 32'h0102_0304, 32'h0000_0100, lat, fb);
    chk("t6_y_shift", y1, 64'h0000_0001_0203_0400);
    for (int k = 0; k < 1000; k++) begin
      ra = pick(); rb = pick();
      op(1, ra, rb, lat, fb);
      chk("t6_lat", 64'(lat), 64'd17);
      chk("t6_y", y1, 64'(ra) * 64'(rb));
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
